// File: rtl/max1270_pkg.sv
// Shared types and constants for the MAX1270 serial scan controller.
// Covers the FSM state enum, frame geometry, control-byte layout and channel helpers.
package max1270_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam int CTRL_BITS    = 8;
  localparam int DEAD_BITS    = 4;
  localparam int DATA_BITS    = 12;
  localparam int FRAME_HALVES = 48;

  localparam int CB_START = 7;
  localparam int CB_CH_HI = 6;
  localparam int CB_CH_LO = 4;
  localparam int CB_RNG   = 3;
  localparam int CB_BIP   = 2;
  localparam int CB_PD_HI = 1;
  localparam int CB_PD_LO = 0;

  localparam logic [1:0] PD_EXTCLK = 2'b01;

  // Half-period index whose end raises SCLK for the first data bit (rising edge 13).
  localparam int SAMPLE_FIRST_HALF = 2 * (CTRL_BITS + DEAD_BITS) - 1;

  function automatic logic [7:0] ctrl_byte(logic [2:0] ch, logic rng, logic bip);
    ctrl_byte = {1'b1, ch, rng, bip, PD_EXTCLK};
  endfunction

  // First enabled channel strictly above cur, wrapping; cur itself only if it is the sole one.
  function automatic logic [2:0] next_ch(logic [7:0] mask, logic [2:0] cur);
    logic [2:0] idx;
    next_ch = cur;
    for (int i = 8; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) next_ch = idx;
    end
  endfunction

  function automatic logic [2:0] top_ch(logic [7:0] mask);
    top_ch = 3'd0;
    for (int i = 0; i < 8; i++)
      if (mask[i]) top_ch = 3'(i);
  endfunction

endpackage

// File: rtl/max1270_sclk_gen.sv
// Half-period timebase for the ADC serial clock.
// tick ends every half-period; rise/fall mark the SCLK edges while run is high.
module max1270_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;

  assign tick = (cnt == CW'(CLK_DIV - 1));
  assign rise = tick & run & ~phase;
  assign fall = tick & run & phase;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (rise || fall) phase <= ~phase;
    end
  end

endmodule

// File: rtl/max1270_scan_ctrl.sv
// MAX1270 external-clock serial master: scans enabled channels round-robin
// and keeps the latest 12-bit raw code for each channel.
module max1270_scan_ctrl
  import max1270_pkg::*;
#(
  parameter int   CLK_DIV   = 4,
  parameter int   IDLE_HALF = 2,
  parameter logic RNG       = 1'b1,
  parameter logic BIP       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iEnable,
  input  logic [7:0]  iChMask,
  output logic        oCSn,
  output logic        oSCLK,
  output logic        oDIN,
  input  logic        iDOUT,
  output logic [11:0] oADCh0Data,
  output logic [11:0] oADCh1Data,
  output logic [11:0] oADCh2Data,
  output logic [11:0] oADCh3Data,
  output logic [11:0] oADCh4Data,
  output logic [11:0] oADCh5Data,
  output logic [11:0] oADCh6Data,
  output logic [11:0] oADCh7Data,
  output logic        oDataValid,
  output logic [2:0]  oChIndex,
  output logic        oScanDone
);
  localparam int GW = (IDLE_HALF > 1) ? $clog2(IDLE_HALF) : 1;

  state_t                          state, state_nxt;
  logic                            start, run, commit, clr;
  logic                            tick, rise, fall;
  logic [5:0]                      bit_cnt;
  logic [GW-1:0]                   gap_cnt;
  logic                            gap_last, shift_last;
  logic [7:0]                      mask;
  logic [2:0]                      ch, ch_sel;
  logic [7:0]                      ctrl_sr, ctrl_new;
  logic [DATA_BITS-1:0]            data_sr;
  logic [7:0][DATA_BITS-1:0]       result;

  max1270_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (tick),
    .rise (rise),
    .fall (fall)
  );

  assign shift_last = (bit_cnt == 6'(FRAME_HALVES - 1));
  assign gap_last   = (gap_cnt == GW'(IDLE_HALF - 1));
  // From IDLE the search starts above ch7 so the lowest enabled channel wins.
  assign ch_sel     = next_ch(iChMask, (state == S_IDLE) ? 3'd7 : ch);
  assign ctrl_new   = ctrl_byte(ch_sel, RNG, BIP);
  assign clr        = start && (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    run       = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (iEnable && (iChMask != 8'h00)) begin
          state_nxt = S_SETUP;
          start     = 1'b1;
        end
      end
      S_SETUP: begin
        run = 1'b1;
        if (tick) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // The final half-period is already low; no toggle into HOLD.
        run = !shift_last;
        if (tick && shift_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (tick) begin
          state_nxt = S_GAP;
          commit    = 1'b1;
        end
      end
      S_GAP: begin
        if (tick && gap_last) begin
          if (iEnable && (iChMask != 8'h00)) begin
            state_nxt = S_SETUP;
            start     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      oCSn       <= 1'b1;
      oSCLK      <= 1'b0;
      oDIN       <= 1'b0;
      oDataValid <= 1'b0;
      oScanDone  <= 1'b0;
      ctrl_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      mask       <= '0;
      ch         <= '0;
      result     <= '0;
    end else begin
      state      <= state_nxt;
      oDataValid <= 1'b0;
      oScanDone  <= 1'b0;
      if (rise) oSCLK <= 1'b1;
      if (fall) begin
        oSCLK   <= 1'b0;
        oDIN    <= ctrl_sr[CTRL_BITS-2];
        ctrl_sr <= {ctrl_sr[CTRL_BITS-2:0], 1'b0};
      end
      if (state == S_SHIFT && tick) bit_cnt <= bit_cnt + 6'd1;
      if (state == S_SHIFT && rise && bit_cnt >= 6'(SAMPLE_FIRST_HALF))
        data_sr <= {data_sr[DATA_BITS-2:0], iDOUT};
      if (state == S_GAP && tick) gap_cnt <= gap_cnt + GW'(1);
      if (commit) begin
        oCSn       <= 1'b1;
        result[ch] <= data_sr;
        oDataValid <= 1'b1;
        oScanDone  <= (ch == top_ch(mask));
        gap_cnt    <= '0;
      end
      if (start) begin
        oCSn    <= 1'b0;
        oDIN    <= ctrl_new[CB_START];
        ctrl_sr <= ctrl_new;
        mask    <= iChMask;
        ch      <= ch_sel;
        bit_cnt <= '0;
      end
    end
  end

  assign oChIndex   = ch;
  assign oADCh0Data = result[0];
  assign oADCh1Data = result[1];
  assign oADCh2Data = result[2];
  assign oADCh3Data = result[3];
  assign oADCh4Data = result[4];
  assign oADCh5Data = result[5];
  assign oADCh6Data = result[6];
  assign oADCh7Data = result[7];

endmodule

// File: tb/tb_max1270_scan_ctrl.sv
// Bench for max1270_scan_ctrl: ADC serial model, table of single-channel frames,
// directed corner sequences and a randomized scan against a channel-order model.
module tb_max1270_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iEnable = 1'b0;
  logic [7:0]  iChMask = 8'h00;
  logic        iDOUT = 1'b0;
  logic        oCSn, oSCLK, oDIN, oDataValid, oScanDone;
  logic [2:0]  oChIndex;
  logic [11:0] oADCh0Data, oADCh1Data, oADCh2Data, oADCh3Data;
  logic [11:0] oADCh4Data, oADCh5Data, oADCh6Data, oADCh7Data;
  logic [11:0] res [8];

  max1270_scan_ctrl dut (
    .clk(clk), .rst(rst), .iEnable(iEnable), .iChMask(iChMask),
    .oCSn(oCSn), .oSCLK(oSCLK), .oDIN(oDIN), .iDOUT(iDOUT),
    .oADCh0Data(oADCh0Data), .oADCh1Data(oADCh1Data), .oADCh2Data(oADCh2Data),
    .oADCh3Data(oADCh3Data), .oADCh4Data(oADCh4Data), .oADCh5Data(oADCh5Data),
    .oADCh6Data(oADCh6Data), .oADCh7Data(oADCh7Data),
    .oDataValid(oDataValid), .oChIndex(oChIndex), .oScanDone(oScanDone)
  );

  always #5 clk = ~clk;

  assign res[0] = oADCh0Data;
  assign res[1] = oADCh1Data;
  assign res[2] = oADCh2Data;
  assign res[3] = oADCh3Data;
  assign res[4] = oADCh4Data;
  assign res[5] = oADCh5Data;
  assign res[6] = oADCh6Data;
  assign res[7] = oADCh7Data;

  typedef struct {
    int          cyc;
    int          ch;
    logic [11:0] data;
    logic        done;
  } ev_t;

  typedef struct {
    logic [7:0]  mask;
    logic [11:0] val;
    int          ch;
    logic [7:0]  ctrl;
    logic        done;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  ev_t         ev_q[$];
  int          csfall_q[$];
  logic [7:0]  ctrl_q[$];
  logic [11:0] adc_val [8];

  // ADC model: reads the control byte on SCLK rises, shifts D11..D0 after falls 12..23.
  logic       a_prev_cs = 1'b1, a_prev_sclk = 1'b0;
  int         rise_n = 0, fall_n = 0;
  logic [7:0] ctrl_in = 8'h00;
  always @(posedge clk) begin
    #2;
    if (a_prev_cs && !oCSn) begin
      rise_n = 0; fall_n = 0; ctrl_in = 8'h00;
    end
    if (!oCSn && !a_prev_sclk && oSCLK) begin
      rise_n++;
      if (rise_n <= 8) ctrl_in = {ctrl_in[6:0], oDIN};
      if (rise_n == 8) ctrl_q.push_back(ctrl_in);
    end
    if (!oCSn && a_prev_sclk && !oSCLK) begin
      fall_n++;
      if (fall_n >= 12 && fall_n <= 23) iDOUT = adc_val[ctrl_in[6:4]][23 - fall_n];
      else iDOUT = 1'b0;
    end
    a_prev_cs = oCSn;
    a_prev_sclk = oSCLK;
  end

  // Monitor: records CSn falls and result-update events.
  logic m_prev_cs = 1'b1;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_prev_cs && !oCSn) csfall_q.push_back(cyc);
    m_prev_cs = oCSn;
    if (oDataValid) ev_q.push_back('{cyc, int'(oChIndex), res[oChIndex], oScanDone});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_ev(input string name, output ev_t e);
    int n = 0;
    while (ev_q.size() == 0 && n < 600) begin @(posedge clk); #2; n++; end
    if (ev_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: timeout waiting for oDataValid", name);
      e = '{-1, -1, 12'h000, 1'b0};
    end else e = ev_q.pop_front();
  endtask

  task automatic get_cs(input string name, output int c);
    int n = 0;
    while (csfall_q.size() == 0 && n < 600) begin @(posedge clk); #2; n++; end
    if (csfall_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: timeout waiting for CSn low", name);
      c = -1;
    end else c = csfall_q.pop_front();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iEnable = 1'b0; iChMask = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ev_q.delete(); csfall_q.delete(); ctrl_q.delete();
  endtask

  // Channel-order model: enabled channels as an ascending list.
  function automatic int next_model(logic [7:0] m, int cur);
    int en[$];
    for (int i = 0; i < 8; i++) if (m[i]) en.push_back(i);
    foreach (en[j]) if (en[j] > cur) return en[j];
    return en[0];
  endfunction

  function automatic int top_model(logic [7:0] m);
    int en[$];
    for (int i = 0; i < 8; i++) if (m[i]) en.push_back(i);
    return en[en.size() - 1];
  endfunction

  vec_t vt [5];

  initial begin
    ev_t e;
    int  c0, prev, exp_ch;
    logic [7:0] m_cur, m_new;
    int  seq81 [4];

    vt[0] = '{8'h08, 12'hA5C, 3, 8'hBD, 1'b1};
    vt[1] = '{8'h01, 12'h001, 0, 8'h8D, 1'b1};
    vt[2] = '{8'h80, 12'hFFF, 7, 8'hFD, 1'b1};
    vt[3] = '{8'h60, 12'h800, 5, 8'hDD, 1'b0};
    vt[4] = '{8'h22, 12'h7FF, 1, 8'h9D, 1'b0};
    seq81 = '{0, 7, 0, 7};

    // Reset state
    do_reset();
    check("rst_csn", 32'(oCSn), 32'd1);
    check("rst_sclk", 32'(oSCLK), 32'd0);
    check("rst_din", 32'(oDIN), 32'd0);
    check("rst_chidx", 32'(oChIndex), 32'd0);
    check("rst_valid", 32'(oDataValid), 32'd0);
    check("rst_done", 32'(oScanDone), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_res%0d", i), 32'(res[i]), 32'd0);

    // Single-channel frames from the table
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 8; i++) adc_val[i] = (i == vt[r].ch) ? vt[r].val : ~vt[r].val;
      @(negedge clk); iChMask = vt[r].mask; iEnable = 1'b1;
      get_cs($sformatf("vec%0d_cs", r), c0);
      get_ev($sformatf("vec%0d_ev", r), e);
      @(negedge clk); iEnable = 1'b0;
      check($sformatf("vec%0d_ch", r), 32'(e.ch), 32'(vt[r].ch));
      check($sformatf("vec%0d_data", r), 32'(e.data), 32'(vt[r].val));
      check($sformatf("vec%0d_done", r), 32'(e.done), 32'(vt[r].done));
      check($sformatf("vec%0d_latency", r), 32'(e.cyc - c0), 32'd200);
      check($sformatf("vec%0d_ctrl", r), 32'(ctrl_q.size() > 0 ? ctrl_q[0] : 8'h00), 32'(vt[r].ctrl));
      repeat (300) @(posedge clk);
      #2;
      check($sformatf("vec%0d_extra_ev", r), 32'(ev_q.size()), 32'd0);
      check($sformatf("vec%0d_idle_csn", r), 32'(oCSn), 32'd1);
    end

    // Full 8-channel scan
    do_reset();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h100 + 12'(i);
    @(negedge clk); iChMask = 8'hFF; iEnable = 1'b1;
    get_cs("ff_cs", c0);
    prev = c0;
    for (int n = 0; n < 8; n++) begin
      get_ev($sformatf("ff_ev%0d", n), e);
      if (n == 7) begin @(negedge clk); iEnable = 1'b0; end
      check($sformatf("ff_ch%0d", n), 32'(e.ch), 32'(n));
      check($sformatf("ff_data%0d", n), 32'(e.data), 32'(12'h100 + 12'(n)));
      check($sformatf("ff_done%0d", n), 32'(e.done), 32'(n == 7));
      check($sformatf("ff_period%0d", n), 32'(e.cyc - prev), (n == 0) ? 32'd200 : 32'd208);
      prev = e.cyc;
    end
    for (int i = 0; i < 8; i++) check($sformatf("ff_res%0d", i), 32'(res[i]), 32'(12'h100 + 12'(i)));

    // Mask 0x81 alternates 0,7
    do_reset();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom_range(1, 4095));
    @(negedge clk); iChMask = 8'h81; iEnable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      get_ev($sformatf("m81_ev%0d", n), e);
      if (n == 3) begin @(negedge clk); iEnable = 1'b0; end
      check($sformatf("m81_ch%0d", n), 32'(e.ch), 32'(seq81[n]));
      check($sformatf("m81_data%0d", n), 32'(e.data), 32'(adc_val[seq81[n]]));
    end
    for (int i = 1; i < 7; i++) check($sformatf("m81_res%0d", i), 32'(res[i]), 32'd0);

    // iEnable dropped around bit 10: frame completes, then idle
    do_reset();
    adc_val[4] = 12'h3C5;
    @(negedge clk); iChMask = 8'h10; iEnable = 1'b1;
    get_cs("drop_cs", c0);
    repeat (44) @(posedge clk);
    @(negedge clk); iEnable = 1'b0;
    get_ev("drop_ev", e);
    check("drop_ch", 32'(e.ch), 32'd4);
    check("drop_data", 32'(e.data), 32'h3C5);
    repeat (400) @(posedge clk);
    #2;
    check("drop_no_ev", 32'(ev_q.size()), 32'd0);
    check("drop_no_setup", 32'(csfall_q.size()), 32'd0);
    check("drop_csn", 32'(oCSn), 32'd1);

    // Mask change 0x01 -> 0x04 mid-frame
    do_reset();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h050 + 12'(i);
    @(negedge clk); iChMask = 8'h01; iEnable = 1'b1;
    get_cs("mchg_cs", c0);
    repeat (50) @(posedge clk);
    @(negedge clk); iChMask = 8'h04;
    get_ev("mchg_ev0", e);
    check("mchg_ch0", 32'(e.ch), 32'd0);
    get_ev("mchg_ev1", e);
    @(negedge clk); iEnable = 1'b0;
    check("mchg_ch1", 32'(e.ch), 32'd2);
    check("mchg_data1", 32'(e.data), 32'h052);

    // Reset during SHIFT, then restart from the lowest enabled channel
    do_reset();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h9A0 + 12'(i);
    @(negedge clk); iChMask = 8'h28; iEnable = 1'b1;
    get_ev("rstm_ev0", e);
    check("rstm_ch0", 32'(e.ch), 32'd3);
    get_cs("rstm_cs1", c0);
    get_cs("rstm_cs1b", c0);
    repeat (84) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rstm_csn", 32'(oCSn), 32'd1);
    check("rstm_sclk", 32'(oSCLK), 32'd0);
    check("rstm_valid", 32'(oDataValid), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rstm_res%0d", i), 32'(res[i]), 32'd0);
    check("rstm_no_ev", 32'(ev_q.size()), 32'd0);
    @(negedge clk); rst = 1'b0;
    ev_q.delete(); csfall_q.delete(); ctrl_q.delete();
    get_cs("rstm_cs2", c0);
    get_ev("rstm_ev2", e);
    @(negedge clk); iEnable = 1'b0;
    check("rstm_restart_ch", 32'(e.ch), 32'd3);
    check("rstm_restart_lat", 32'(e.cyc - c0), 32'd200);
    check("rstm_restart_data", 32'(e.data), 32'h9A3);

    // Randomized scans with mask changes between frames
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      m_cur = 8'($urandom_range(1, 255));
      exp_ch = next_model(m_cur, -1);
      @(negedge clk); iChMask = m_cur; iEnable = 1'b1;
      for (int k = 0; k < 8; k++) begin
        get_cs($sformatf("rnd%0d_cs%0d", it, k), c0);
        repeat ($urandom_range(5, 180)) @(posedge clk);
        m_new = 8'($urandom_range(1, 255));
        @(negedge clk);
        if (k == 7) iEnable = 1'b0;
        else iChMask = m_new;
        get_ev($sformatf("rnd%0d_ev%0d", it, k), e);
        check($sformatf("rnd%0d_ch%0d", it, k), 32'(e.ch), 32'(exp_ch));
        check($sformatf("rnd%0d_data%0d", it, k), 32'(e.data), 32'(adc_val[exp_ch]));
        check($sformatf("rnd%0d_done%0d", it, k), 32'(e.done), 32'(exp_ch == top_model(m_cur)));
        check($sformatf("rnd%0d_lat%0d", it, k), 32'(e.cyc - c0), 32'd200);
        exp_ch = next_model(m_new, exp_ch);
        m_cur = m_new;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
